// File: rtl/gamma_cycle_sequencer.sv
// gamma_cycle_sequencer
// Runs one gamma cycle for a bank of race-logic primitives. It pulses the
// primitive reset, replays the input spike times as fixed-width pulses, and
// records the first rising edge seen on each datapath output lane. The
// recorded times are then returned over a valid/ready handshake.
// Every output comes straight from a register.
module gamma_cycle_sequencer #(
   parameter int GAMMA_CYCLE_WIDTH = 16,
   parameter int PULSE_WIDTH       = 8,
   parameter int RST_CYCLES        = 2,
   parameter int NUM_IN            = 4,
   parameter int NUM_OUT           = 4
) (
   input  logic                                           aclk,
   input  logic                                           grst,
   input  logic                                           in_valid,
   output logic                                           in_ready,
   input  logic [NUM_IN*$clog2(GAMMA_CYCLE_WIDTH+1)-1:0]  in_times,
   output logic                                           gamma_rst,
   output logic [NUM_IN-1:0]                              spikes_out,
   input  logic [NUM_OUT-1:0]                             q_in,
   output logic [$clog2(GAMMA_CYCLE_WIDTH+1)-1:0]         gamma_t,
   output logic                                           busy,
   output logic                                           out_valid,
   input  logic                                           out_ready,
   output logic [NUM_OUT*$clog2(GAMMA_CYCLE_WIDTH+1)-1:0] out_times
);

   localparam int TW  = $clog2(GAMMA_CYCLE_WIDTH+1);
   localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [TW-1:0] NO_SPIKE = TW'(GAMMA_CYCLE_WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_RESET, S_RUN, S_REPORT} state_t;

   state_t                  r_state;
   state_t                  w_nxt;
   logic [RCW-1:0]          r_rst_cnt;
   logic [NUM_IN*TW-1:0]    r_times;
   logic [NUM_OUT-1:0]      r_q_prev;
   logic [NUM_OUT*TW-1:0]   r_out_times;
   logic                    r_in_ready;
   logic                    r_gamma_rst;
   logic [NUM_IN-1:0]       r_spikes;
   logic [TW-1:0]           r_gamma_t;
   logic                    r_busy;
   logic                    r_out_valid;

   logic                    w_accept;
   logic                    w_run_last;
   logic                    w_rst_last;
   logic [TW-1:0]           w_gt_nxt;
   logic [NUM_IN-1:0]       w_spk_nxt;
   logic                    w_in_ready_nxt;

   // in_ready is only ever high while IDLE, so it alone qualifies an accept
   assign w_accept   = in_valid && r_in_ready;
   assign w_run_last = (r_gamma_t == TW'(GAMMA_CYCLE_WIDTH-1));
   assign w_rst_last = (r_rst_cnt == RCW'(RST_CYCLES-1));

   // State register
   always_ff @(posedge aclk) begin
      if (grst) r_state <= S_IDLE;
      else      r_state <= w_nxt;
   end

   // Next-state logic
   always_comb begin
      w_nxt = r_state;
      case (r_state)
         S_IDLE:   if (w_accept)   w_nxt = S_RESET;
         S_RESET:  if (w_rst_last) w_nxt = S_RUN;
         S_RUN:    if (w_run_last) w_nxt = S_REPORT;
         S_REPORT: if (out_ready)  w_nxt = S_IDLE;
         default:                  w_nxt = S_IDLE;
      endcase
   end

   // Next-cycle output values, aligned with the state being entered
   always_comb begin
      w_gt_nxt  = '0;
      w_spk_nxt = '0;
      // in_ready rises one cycle after IDLE is entered. That extra cycle
      // gives a back-to-back period of RST_CYCLES+GAMMA_CYCLE_WIDTH+3.
      w_in_ready_nxt = (r_state == S_IDLE) && (w_nxt == S_IDLE);
      if ((r_state == S_RUN) && (w_nxt == S_RUN))
         w_gt_nxt = r_gamma_t + TW'(1);
      for (int i = 0; i < NUM_IN; i++) begin
         w_spk_nxt[i] = (w_nxt == S_RUN)
            && (32'(r_times[i*TW +: TW]) < 32'(GAMMA_CYCLE_WIDTH))
            && (32'(w_gt_nxt) >= 32'(r_times[i*TW +: TW]))
            && (32'(w_gt_nxt) <  32'(r_times[i*TW +: TW]) + 32'(PULSE_WIDTH));
      end
   end

   // Gamma-reset cycle counter, restarted on every accept
   always_ff @(posedge aclk) begin
      if (grst)                   r_rst_cnt <= '0;
      else if (w_accept)          r_rst_cnt <= '0;
      else if (r_state == S_RESET) r_rst_cnt <= r_rst_cnt + RCW'(1);
   end

   // Input latch, q history and first-edge capture
   always_ff @(posedge aclk) begin
      if (grst) begin
         r_times     <= '0;
         r_q_prev    <= '0;
         r_out_times <= {NUM_OUT{NO_SPIKE}};
      end else begin
         if (w_accept) begin
            r_times     <= in_times;
            r_out_times <= {NUM_OUT{NO_SPIKE}};
            r_q_prev    <= '0;
         end
         // q history starts clear, so a q already high at t=0 counts as an edge
         if ((w_nxt == S_RUN) && (r_state != S_RUN))
            r_q_prev <= '0;
         else if (r_state == S_RUN)
            r_q_prev <= q_in;
         if (r_state == S_RUN) begin
            for (int j = 0; j < NUM_OUT; j++) begin
               if (q_in[j] && !r_q_prev[j] && (r_out_times[j*TW +: TW] == NO_SPIKE))
                  r_out_times[j*TW +: TW] <= r_gamma_t;
            end
         end
      end
   end

   // Registered outputs
   always_ff @(posedge aclk) begin
      if (grst) begin
         r_in_ready  <= 1'b1;
         r_gamma_rst <= 1'b0;
         r_spikes    <= '0;
         r_gamma_t   <= '0;
         r_busy      <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         r_in_ready  <= w_in_ready_nxt;
         r_gamma_rst <= (w_nxt == S_RESET);
         r_spikes    <= w_spk_nxt;
         r_gamma_t   <= w_gt_nxt;
         r_busy      <= (w_nxt != S_IDLE);
         r_out_valid <= (w_nxt == S_REPORT);
      end
   end

   assign in_ready   = r_in_ready;
   assign gamma_rst  = r_gamma_rst;
   assign spikes_out = r_spikes;
   assign gamma_t    = r_gamma_t;
   assign busy       = r_busy;
   assign out_valid  = r_out_valid;
   assign out_times  = r_out_times;

endmodule

// File: tb/tb_gamma_cycle_sequencer.sv
// Directed bench for gamma_cycle_sequencer at default parameters.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_gamma_cycle_sequencer;

   logic        aclk = 1'b0;
   logic        grst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [19:0] in_times = '0;
   logic        gamma_rst;
   logic [3:0]  spikes_out;
   logic [3:0]  q_in = '0;
   logic [4:0]  gamma_t;
   logic        busy;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [19:0] out_times;

   int n_chk  = 0;
   int n_fail = 0;

   gamma_cycle_sequencer dut (
      .aclk(aclk), .grst(grst), .in_valid(in_valid), .in_ready(in_ready),
      .in_times(in_times), .gamma_rst(gamma_rst), .spikes_out(spikes_out),
      .q_in(q_in), .gamma_t(gamma_t), .busy(busy), .out_valid(out_valid),
      .out_ready(out_ready), .out_times(out_times)
   );

   always #5 aclk = ~aclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [19:0] pk(input int a0, input int a1, input int a2, input int a3);
      return {a3[4:0], a2[4:0], a1[4:0], a0[4:0]};
   endfunction

   // mode 0: times {3,0,16,15}, q idle. mode 1: times {31,17,0,12} with the q pattern below.
   function automatic logic [3:0] exp_spk(input int mode, input int t);
      logic [3:0] s;
      if (mode == 0) s = {t == 15, 1'b0, t <= 7, (t >= 3) && (t <= 10)};
      else           s = {t >= 12, t <= 7, 1'b0, 1'b0};
      return s;
   endfunction

   function automatic logic [3:0] q_pat(input int t);
      return {1'b0, t >= 15, 1'b1, ((t >= 5) && (t < 7)) || (t >= 9)};
   endfunction

   // Accept at cycle 0, then walk cycles 1..19 checking the sequence
   task automatic run_op(input int mode, input logic [19:0] times);
      chk("accept_ready", 32'(in_ready), 1);
      in_valid = 1'b1;
      in_times = times;
      for (int k = 1; k <= 19; k++) begin
         @(negedge aclk);
         in_valid = 1'b0;
         chk($sformatf("m%0d_grst_c%0d", mode, k), 32'(gamma_rst), 32'((k == 1) || (k == 2)));
         chk($sformatf("m%0d_gt_c%0d", mode, k), 32'(gamma_t), (k >= 3 && k <= 18) ? 32'(k-3) : 0);
         chk($sformatf("m%0d_spk_c%0d", mode, k), 32'(spikes_out),
             (k >= 3 && k <= 18) ? 32'(exp_spk(mode, k-3)) : 0);
         chk($sformatf("m%0d_ovld_c%0d", mode, k), 32'(out_valid), 32'(k == 19));
         chk($sformatf("m%0d_busy_c%0d", mode, k), 32'(busy), 1);
         if (mode == 1) q_in = (k <= 18) ? q_pat(k-3) : 4'h0;
      end
   endtask

   initial begin
      // 1: reset
      @(negedge aclk);
      grst = 1'b1;
      repeat (2) @(negedge aclk);
      grst = 1'b0;
      chk("rst_in_ready",  32'(in_ready),   1);
      chk("rst_busy",      32'(busy),       0);
      chk("rst_gamma_rst", 32'(gamma_rst),  0);
      chk("rst_spikes",    32'(spikes_out), 0);
      chk("rst_out_valid", 32'(out_valid),  0);
      chk("rst_gamma_t",   32'(gamma_t),    0);
      chk("rst_out_times", 32'(out_times),  32'(pk(16,16,16,16)));

      // 2: pulse replay with no datapath activity
      run_op(0, pk(3,0,16,15));
      chk("t2_out_times", 32'(out_times), 32'(pk(16,16,16,16)));
      chk("t2_in_ready_rep", 32'(in_ready), 0);
      out_ready = 1'b1;
      @(negedge aclk);
      out_ready = 1'b0;
      chk("t2_ovld_after", 32'(out_valid), 0);
      chk("t2_busy_after", 32'(busy), 0);
      chk("t2_rdy_gap", 32'(in_ready), 0);
      @(negedge aclk);
      chk("t2_rdy_back", 32'(in_ready), 1);

      // 3: edge capture, above-range times, truncated pulse
      run_op(1, pk(31,17,0,12));
      chk("t3_out_times", 32'(out_times), 32'(pk(5,0,15,16)));

      // 4: stall in REPORT with a stray in_valid
      for (int n = 0; n < 10; n++) begin
         chk($sformatf("t4_ovld_%0d", n), 32'(out_valid), 1);
         chk($sformatf("t4_times_%0d", n), 32'(out_times), 32'(pk(5,0,15,16)));
         chk($sformatf("t4_rdy_%0d", n), 32'(in_ready), 0);
         in_valid = (n == 3);
         in_times = pk(1,1,1,1);
         @(negedge aclk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge aclk);
      out_ready = 1'b0;
      chk("t4_ovld_done", 32'(out_valid), 0);
      chk("t4_busy_done", 32'(busy), 0);
      @(negedge aclk);
      chk("t4_idle_rdy", 32'(in_ready), 1);
      chk("t4_idle_busy", 32'(busy), 0);
      chk("t4_retained", 32'(out_times), 32'(pk(5,0,15,16)));

      // 5: grst mid-RUN
      in_valid = 1'b1;
      in_times = pk(0,0,0,0);
      for (int k = 1; k <= 9; k++) begin
         @(negedge aclk);
         in_valid = 1'b0;
      end
      chk("t5_gt6", 32'(gamma_t), 6);
      chk("t5_spk", 32'(spikes_out), 32'hF);
      grst = 1'b1;
      @(negedge aclk);
      grst = 1'b0;
      chk("t5_busy", 32'(busy), 0);
      chk("t5_spk0", 32'(spikes_out), 0);
      chk("t5_gt0", 32'(gamma_t), 0);
      chk("t5_rdy", 32'(in_ready), 1);
      chk("t5_times", 32'(out_times), 32'(pk(16,16,16,16)));
      for (int k = 0; k < 30; k++) begin
         @(negedge aclk);
         chk($sformatf("t5_no_ovld_%0d", k), 32'(out_valid), 0);
      end

      // 6: back-to-back operations
      in_valid  = 1'b1;
      out_ready = 1'b1;
      in_times  = pk(2,2,2,2);
      for (int k = 0; k <= 62; k++) begin
         chk($sformatf("t6_ovld_c%0d", k), 32'(out_valid), 32'((k == 19) || (k == 40) || (k == 61)));
         chk($sformatf("t6_rdy_c%0d", k), 32'(in_ready), 32'((k == 0) || (k == 21) || (k == 42)));
         @(negedge aclk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      @(negedge aclk);
      chk("t6_final_idle", 32'(busy), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
